// File: rtl/pixel_readout_buffer.sv
// Row-word FIFO between the pixel readout buses and an 8-bit valid/ready pixel stream.
// Each strobe captures four pixels. They are sent out LSB-first, with sof, eol and eof markers.
module pixel_readout_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ROWS  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             pixdata1,
  input  logic [15:0]             pixdata2,
  input  logic                    pix_valid,
  input  logic                    frame_start,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sof,
  output logic                    out_eol,
  output logic                    out_eof,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic                    overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {S_EMPTY, S_SHIFT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     word_q, word_d;
  logic [RW-1:0]   row_q, row_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            sof_q, sof_d;
  logic            eol_q, eol_d;
  logic            eof_q, eof_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            sof_pend_q, sof_pend_d;
  logic [32:0]     mem_q [DEPTH];

  logic            push, pop, accept, tag;
  logic [32:0]     rd_word;
  logic [1:0]      nxt_idx;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    row_d      = row_q;
    data_d     = data_q;
    valid_d    = valid_q;
    sof_d      = sof_q;
    eol_d      = eol_q;
    eof_d      = eof_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    nxt_idx    = idx_q + 2'd1;
    rd_word    = mem_q[rd_ptr_q];

    // A full FIFO refuses the strobe even when a pop happens in the same cycle.
    push       = pix_valid && (count_q != CW'(DEPTH));
    accept     = valid_q && out_ready;
    pop        = (count_q != '0) &&
                 ((state_q == S_EMPTY) || (accept && (idx_q == 2'd3)));
    tag        = sof_pend_q || frame_start;
    sof_pend_d = push ? 1'b0 : tag;

    if (pix_valid && !push) ovf_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      state_d = S_SHIFT;
      idx_d   = 2'd0;
      word_d  = rd_word[31:0];
      row_d   = rd_word[32] ? '0 :
                ((row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1));
      valid_d = 1'b1;
      data_d  = rd_word[7:0];
      sof_d   = rd_word[32];
      eol_d   = 1'b0;
      eof_d   = 1'b0;
    end else if (accept) begin
      if (idx_q == 2'd3) begin
        state_d = S_EMPTY;
        valid_d = 1'b0;
        data_d  = 8'd0;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        eof_d   = 1'b0;
      end else begin
        idx_d   = nxt_idx;
        data_d  = word_q[{nxt_idx, 3'b000} +: 8];
        sof_d   = 1'b0;
        eol_d   = (nxt_idx == 2'd3);
        eof_d   = (nxt_idx == 2'd3) && (row_q == RW'(ROWS - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      idx_q      <= 2'd0;
      word_q     <= 32'd0;
      row_q      <= '0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      eof_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      sof_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      row_q      <= row_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      eof_q      <= eof_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      sof_pend_q <= sof_pend_d;
    end
  end

  // Storage needs no reset: the pointers and the count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {tag, pixdata2, pixdata1};
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign out_sof    = sof_q;
  assign out_eol    = eol_q;
  assign out_eof    = eof_q;
  assign fill_level = count_q;
  assign overflow   = ovf_q;

endmodule
